// File: rtl/isp_sat_pkg.sv
// Shared constants and width helpers for the saturation-adjust stage.
// Luma uses fixed 10-bit fractional BT.601-style coefficients.
package isp_sat_pkg;

  localparam int NCOMP       = 32'sd3;
  localparam int STAGES      = 32'sd4;
  localparam int LUMA_COEF_W = 32'sd10;
  localparam int LUMA_SHIFT  = 32'sd10;

  localparam logic [LUMA_COEF_W-1:0] LUMA_R = 10'd306;
  localparam logic [LUMA_COEF_W-1:0] LUMA_G = 10'd601;
  localparam logic [LUMA_COEF_W-1:0] LUMA_B = 10'd117;

  // Signed width of S = X*(2^cw+v) - Y*v: bits for the largest magnitude plus sign.
  function automatic int sat_s_width(input int cw);
    longint max_mag;
    longint one_l;
    int     w;
    one_l   = 64'sd1;
    max_mag = ((one_l << cw) - one_l) * ((one_l << (cw + 32'sd1)) - one_l)
            + ((one_l << cw) - one_l) * (one_l << cw);
    w = 32'sd0;
    while ((one_l << w) <= max_mag) begin
      w = w + 32'sd1;
    end
    return w + 32'sd1;
  endfunction

endpackage

// File: rtl/sat_adj_lane.sv
// Per-pixel 4-stage saturation datapath; all stages advance together on I_en.
// Bypass data rides the same stages so both modes have identical latency.
module sat_adj_lane
  import isp_sat_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_en,
  input  logic [3*CW-1:0]     I_pixel,
  input  logic signed [CW:0]  I_adjust_val,
  input  logic                I_bypass,
  output logic [3*CW-1:0]     O_pixel
);

  localparam int S_W    = sat_s_width(CW);
  localparam int PROD_W = CW + LUMA_COEF_W;
  localparam int SUM_W  = PROD_W + 32'sd2;

  logic [PROD_W-1:0]     prod_r_r, prod_g_r, prod_b_r;
  logic [3*CW-1:0]       x0_r, x1_r, x2_r, out3_r;
  logic signed [CW:0]    v0_r, v1_r;
  logic                  byp0_r, byp1_r, byp2_r;
  logic [CW-1:0]         y1_r;
  logic signed [CW+1:0]  factor1_r;
  logic signed [S_W-1:0] xf2_r [NCOMP];
  logic signed [S_W-1:0] yv2_r;

  logic [SUM_W-1:0]      luma_sum_s;
  logic [CW-1:0]         luma_y_s;
  logic signed [CW+1:0]  factor_s;
  logic signed [S_W-1:0] factor_ext_s, y_ext_s, v_ext_s, yv_s;
  logic signed [S_W-1:0] xf_s [NCOMP];
  logic signed [S_W-1:0] hi_s [NCOMP];
  logic [3*CW-1:0]       clamp_s;

  // Luma, factor, products and floor/clamp; negative S clamps to zero.
  always_comb begin
    luma_sum_s   = SUM_W'(prod_r_r) + SUM_W'(prod_g_r) + SUM_W'(prod_b_r);
    luma_y_s     = CW'(luma_sum_s >> LUMA_SHIFT);
    factor_s     = {2'b01, {CW{1'b0}}} + {v0_r[CW], v0_r};
    factor_ext_s = {{(S_W-CW-2){factor1_r[CW+1]}}, factor1_r};
    y_ext_s      = $signed({{(S_W-CW){1'b0}}, y1_r});
    v_ext_s      = {{(S_W-CW-1){v1_r[CW]}}, v1_r};
    yv_s         = y_ext_s * v_ext_s;
    clamp_s      = {(3*CW){1'b0}};
    for (int c = 32'sd0; c < NCOMP; c++) begin
      xf_s[c] = $signed({{(S_W-CW){1'b0}}, x1_r[c*CW +: CW]}) * factor_ext_s;
      hi_s[c] = (xf2_r[c] - yv2_r) >>> CW;
      if (hi_s[c][S_W-1]) begin
        clamp_s[c*CW +: CW] = {CW{1'b0}};
      end else if (|hi_s[c][S_W-2:CW]) begin
        clamp_s[c*CW +: CW] = {CW{1'b1}};
      end else begin
        clamp_s[c*CW +: CW] = hi_s[c][CW-1:0];
      end
    end
  end

  // Pipeline registers, frozen while I_en is low.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      prod_r_r  <= {PROD_W{1'b0}};
      prod_g_r  <= {PROD_W{1'b0}};
      prod_b_r  <= {PROD_W{1'b0}};
      x0_r      <= {(3*CW){1'b0}};
      x1_r      <= {(3*CW){1'b0}};
      x2_r      <= {(3*CW){1'b0}};
      out3_r    <= {(3*CW){1'b0}};
      v0_r      <= {(CW+1){1'b0}};
      v1_r      <= {(CW+1){1'b0}};
      byp0_r    <= 1'b0;
      byp1_r    <= 1'b0;
      byp2_r    <= 1'b0;
      y1_r      <= {CW{1'b0}};
      factor1_r <= {(CW+2){1'b0}};
      yv2_r     <= {S_W{1'b0}};
      for (int c = 32'sd0; c < NCOMP; c++) begin
        xf2_r[c] <= {S_W{1'b0}};
      end
    end else if (I_en) begin
      prod_r_r  <= PROD_W'(I_pixel[2*CW +: CW]) * PROD_W'(LUMA_R);
      prod_g_r  <= PROD_W'(I_pixel[CW +: CW]) * PROD_W'(LUMA_G);
      prod_b_r  <= PROD_W'(I_pixel[0 +: CW]) * PROD_W'(LUMA_B);
      x0_r      <= I_pixel;
      v0_r      <= I_adjust_val;
      byp0_r    <= I_bypass;
      y1_r      <= luma_y_s;
      factor1_r <= factor_s;
      v1_r      <= v0_r;
      x1_r      <= x0_r;
      byp1_r    <= byp0_r;
      for (int c = 32'sd0; c < NCOMP; c++) begin
        xf2_r[c] <= xf_s[c];
      end
      yv2_r     <= yv_s;
      x2_r      <= x1_r;
      byp2_r    <= byp1_r;
      out3_r    <= byp2_r ? x2_r : clamp_s;
    end
  end

  assign O_pixel = out3_r;

endmodule

// File: rtl/image_saturation_adjust_axis.sv
// AXI-Stream saturation adjust: PPC lanes, frame-latched value, 4-stage pipeline.
// I_tready is combinational from O_tready so a stalled pipeline never drops beats.
module image_saturation_adjust_axis
  import isp_sat_pkg::*;
#(
  parameter int                   PPC         = 4,
  parameter int                   CW          = 8,
  parameter logic signed [CW:0]   ADJUST_INIT = {(CW+1){1'b0}}
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic signed [CW:0]      I_adjust_val,
  input  logic                    I_bypass,
  input  logic [PPC*3*CW-1:0]     I_tdata,
  input  logic                    I_tvalid,
  input  logic                    I_tuser,
  input  logic                    I_tlast,
  output logic                    I_tready,
  output logic [PPC*3*CW-1:0]     O_tdata,
  output logic                    O_tvalid,
  output logic                    O_tuser,
  output logic                    O_tlast,
  input  logic                    O_tready,
  output logic signed [CW:0]      O_adj_active
);

  logic [STAGES-1:0]   valid_r, user_r, last_r;
  logic signed [CW:0]  active_val_r;
  logic                active_byp_r;

  logic                en_s, accept_s, frame_start_s;
  logic signed [CW:0]  eff_val_s;
  logic                eff_byp_s;

  // Handshake and the value seen by the beat entering stage 0 this cycle.
  always_comb begin
    en_s          = O_tready | ~valid_r[STAGES-1];
    accept_s      = I_tvalid & en_s;
    frame_start_s = accept_s & I_tuser;
    if (frame_start_s) begin
      eff_val_s = I_adjust_val;
      eff_byp_s = I_bypass;
    end else begin
      eff_val_s = active_val_r;
      eff_byp_s = active_byp_r;
    end
  end

  // Frame-boundary value latch plus valid/sideband shift register.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      valid_r      <= {STAGES{1'b0}};
      user_r       <= {STAGES{1'b0}};
      last_r       <= {STAGES{1'b0}};
      active_val_r <= ADJUST_INIT;
      active_byp_r <= 1'b0;
    end else begin
      if (frame_start_s) begin
        active_val_r <= I_adjust_val;
        active_byp_r <= I_bypass;
      end
      if (en_s) begin
        valid_r <= {valid_r[STAGES-2:0], accept_s};
        user_r  <= {user_r[STAGES-2:0], accept_s & I_tuser};
        last_r  <= {last_r[STAGES-2:0], accept_s & I_tlast};
      end
    end
  end

  for (genvar k = 32'sd0; k < PPC; k++) begin : g_lane
    sat_adj_lane #(.CW(CW)) u_lane (
      .I_clk        (I_clk),
      .I_rst_n      (I_rst_n),
      .I_en         (en_s),
      .I_pixel      (I_tdata[k*3*CW +: 3*CW]),
      .I_adjust_val (eff_val_s),
      .I_bypass     (eff_byp_s),
      .O_pixel      (O_tdata[k*3*CW +: 3*CW])
    );
  end

  assign I_tready     = en_s;
  assign O_tvalid     = valid_r[STAGES-1];
  assign O_tuser      = user_r[STAGES-1];
  assign O_tlast      = last_r[STAGES-1];
  assign O_adj_active = active_val_r;

endmodule

// File: tb/tb_image_saturation_adjust_axis.sv
// Directed self-checking bench for image_saturation_adjust_axis (PPC=4, CW=8).
module tb_image_saturation_adjust_axis;

  localparam int PPC = 4;
  localparam int CW  = 8;
  localparam int DW  = PPC * 3 * CW;
  localparam logic signed [CW:0] ADJ_INIT = 9'sd0;

  logic                I_clk = 1'b0;
  logic                I_rst_n = 1'b0;
  logic signed [CW:0]  I_adjust_val = 9'sd0;
  logic                I_bypass = 1'b0;
  logic [DW-1:0]       I_tdata = '0;
  logic                I_tvalid = 1'b0;
  logic                I_tuser = 1'b0;
  logic                I_tlast = 1'b0;
  logic                I_tready;
  logic [DW-1:0]       O_tdata;
  logic                O_tvalid;
  logic                O_tuser;
  logic                O_tlast;
  logic                O_tready = 1'b1;
  logic signed [CW:0]  O_adj_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;

  image_saturation_adjust_axis #(.PPC(PPC), .CW(CW), .ADJUST_INIT(ADJ_INIT)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_adjust_val(I_adjust_val), .I_bypass(I_bypass),
    .I_tdata(I_tdata), .I_tvalid(I_tvalid), .I_tuser(I_tuser), .I_tlast(I_tlast),
    .I_tready(I_tready), .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tuser(O_tuser),
    .O_tlast(O_tlast), .O_tready(O_tready), .O_adj_active(O_adj_active)
  );

  // Drive one cycle of inputs on the falling edge, then settle before sampling.
  task automatic step(input logic vld, input logic [DW-1:0] d, input logic u, input logic l,
                      input logic ordy, input logic signed [CW:0] adj, input logic byp);
    @(negedge I_clk);
    I_tvalid = vld; I_tdata = d; I_tuser = u; I_tlast = l;
    O_tready = ordy; I_adjust_val = adj; I_bypass = byp;
    #1;
  endtask

  task automatic test_reset;
    I_rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd0, 1'b0);
    I_rst_n = 1'b1;
    checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", O_tvalid); end
    checks++; if (O_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", O_tdata); end
    checks++; if (O_tuser !== 1'b0 || O_tlast !== 1'b0) begin errors++; $display("FAIL reset_sideband: got user=%0b last=%0b expected 0 0", O_tuser, O_tlast); end
    checks++; if (O_adj_active !== ADJ_INIT) begin errors++; $display("FAIL reset_adj_active: got %0d expected %0d", O_adj_active, ADJ_INIT); end
    checks++; if (I_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b expected 1", I_tready); end
  endtask

  task automatic test_identity;
    logic [DW-1:0] exp_q[$];
    logic          exp_l_q[$];
    int            cyc_q[$];
    logic [DW-1:0] d, e;
    logic          el;
    int            c0;
    int sent = 0, got = 0;
    for (int g = 0; g < 1100 && got < 1000; g++) begin
      d = {$urandom, $urandom, $urandom};
      if (sent < 1000) step(1'b1, d, sent == 0, (sent % 16) == 15, 1'b1, 9'sd0, 1'b0);
      else             step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd0, 1'b0);
      if (I_tvalid && I_tready) begin
        exp_q.push_back(d); exp_l_q.push_back(I_tlast); cyc_q.push_back(cyc); sent++;
      end
      if (got > 0 && got < 1000) begin
        checks++; if (O_tvalid !== 1'b1) begin errors++; $display("FAIL identity_gap: got tvalid=%0b expected 1 after beat %0d", O_tvalid, got); end
      end
      if (O_tvalid && O_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL identity_extra: got unexpected beat %h expected none", O_tdata);
        end else begin
          e = exp_q.pop_front(); el = exp_l_q.pop_front(); c0 = cyc_q.pop_front();
          checks++; if (O_tdata !== e) begin errors++; $display("FAIL identity_data%0d: got %h expected %h", got, O_tdata, e); end
          checks++; if (O_tlast !== el) begin errors++; $display("FAIL identity_last%0d: got %0b expected %0b", got, O_tlast, el); end
          checks++; if (cyc - c0 != 4) begin errors++; $display("FAIL identity_latency%0d: got %0d expected 4", got, cyc - c0); end
        end
        got++;
      end
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL identity_count: got %0d expected 1000", got); end
  endtask

  task automatic test_greyscale;
    logic [DW-1:0] din [2];
    logic [DW-1:0] dexp [2];
    din[0]  = {4{24'hFF0000}};
    dexp[0] = {4{24'h4C4C4C}};
    din[1]  = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    dexp[1] = {24'hFFFFFF, 24'h1D1D1D, 24'h959595, 24'h4C4C4C};
    for (int i = 0; i < 6; i++) begin
      if (i < 2) step(1'b1, din[i], i == 0, i == 1, 1'b1, 9'sh100, 1'b0);
      else       step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sh100, 1'b0);
      if (i >= 4) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== dexp[i-4] || O_tuser !== (i == 4) || O_tlast !== (i == 5)) begin
          errors++; $display("FAIL grey_beat%0d: got v=%0b u=%0b l=%0b d=%h expected v=1 d=%h", i - 4, O_tvalid, O_tuser, O_tlast, O_tdata, dexp[i-4]);
        end
      end
    end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b1, {4{24'hC86432}}, 1'b1, 1'b1, 1'b1, 9'sd255, 1'b0);
      else        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd255, 1'b0);
      if (i == 1) begin
        checks++; if (O_adj_active !== 9'sd255) begin errors++; $display("FAIL clamp_adj_active: got %0d expected 255", O_adj_active); end
      end
      if (i == 4) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== {4{24'hFF4C00}}) begin
          errors++; $display("FAIL clamp_data: got v=%0b d=%h expected v=1 d=%h", O_tvalid, O_tdata, {4{24'hFF4C00}});
        end
      end
    end
  endtask

  task automatic test_bypass;
    logic [DW-1:0] dexp [3];
    logic          byp  [3];
    dexp[0] = {4{24'hC86432}}; byp[0] = 1'b1;
    dexp[1] = {4{24'hC86432}}; byp[1] = 1'b0;
    dexp[2] = {4{24'hFF4C00}}; byp[2] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1'b1, {4{24'hC86432}}, i != 1, 1'b0, 1'b1, 9'sd255, byp[i]);
      else       step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd255, 1'b0);
      if (i >= 4) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== dexp[i-4]) begin
          errors++; $display("FAIL bypass_beat%0d: got v=%0b d=%h expected v=1 d=%h", i - 4, O_tvalid, O_tdata, dexp[i-4]);
        end
      end
    end
  endtask

  task automatic test_frame_latch;
    logic signed [CW:0] adj  [5];
    logic [DW-1:0]      dexp [5];
    for (int j = 0; j < 5; j++) begin
      adj[j]  = (j == 0) ? 9'sd0 : 9'sh100;
      dexp[j] = (j == 4) ? {4{24'h4C4C4C}} : {4{24'hFF0000}};
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 5) step(1'b1, {4{24'hFF0000}}, i == 0 || i == 4, 1'b0, 1'b1, adj[i], 1'b0);
      else       step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sh100, 1'b0);
      if (i == 4) begin
        checks++; if (O_adj_active !== 9'sd0) begin errors++; $display("FAIL latch_ignored: got %0d expected 0", O_adj_active); end
      end
      if (i == 5) begin
        checks++; if (O_adj_active !== 9'sh100) begin errors++; $display("FAIL latch_captured: got %0d expected -256", O_adj_active); end
      end
      if (i >= 4) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== dexp[i-4]) begin
          errors++; $display("FAIL latch_beat%0d: got v=%0b d=%h expected v=1 d=%h", i - 4, O_tvalid, O_tdata, dexp[i-4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall;
    logic [DW-1:0] exp_q[$];
    logic          exp_l_q[$];
    logic [DW-1:0] d, e, data_prev;
    logic          l, el, last_prev, ordy;
    logic          hold_prev = 1'b0;
    int sent = 0, got = 0;
    d = {$urandom, $urandom, $urandom}; l = 1'b0;
    for (int t = 0; t < 300 && got < 40; t++) begin
      ordy = (t % 7) >= 3;
      if (sent < 40) step(1'b1, d, sent == 0, l, ordy, 9'sd0, 1'b0);
      else           step(1'b0, '0, 1'b0, 1'b0, ordy, 9'sd0, 1'b0);
      checks++; if (I_tready !== (O_tready | ~O_tvalid)) begin errors++; $display("FAIL stall_tready: got %0b expected %0b", I_tready, O_tready | ~O_tvalid); end
      if (hold_prev) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== data_prev || O_tlast !== last_prev) begin
          errors++; $display("FAIL stall_hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b", O_tvalid, O_tdata, O_tlast, data_prev, last_prev);
        end
      end
      hold_prev = O_tvalid && !O_tready; data_prev = O_tdata; last_prev = O_tlast;
      if (I_tvalid && I_tready) begin
        exp_q.push_back(d); exp_l_q.push_back(l); sent++;
        d = {$urandom, $urandom, $urandom}; l = 1'($urandom_range(0, 1));
      end
      if (O_tvalid && O_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL stall_extra: got unexpected beat %h expected none", O_tdata);
        end else begin
          e = exp_q.pop_front(); el = exp_l_q.pop_front();
          checks++;
          if (O_tdata !== e || O_tlast !== el) begin
            errors++; $display("FAIL stall_beat%0d: got d=%h l=%0b expected d=%h l=%0b", got, O_tdata, O_tlast, e, el);
          end
        end
        got++;
      end
    end
    checks++; if (got != 40 || exp_q.size() != 0) begin errors++; $display("FAIL stall_count: got %0d beats %0d pending expected 40 0", got, exp_q.size()); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) step(1'b1, {4{24'hFF0000}}, i == 0, 1'b0, 1'b1, 9'sh100, 1'b0);
    @(negedge I_clk);
    I_rst_n = 1'b0; I_tvalid = 1'b0; I_tuser = 1'b0;
    #1;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    #1;
    checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %0b expected 0", O_tvalid); end
    checks++; if (O_adj_active !== ADJ_INIT) begin errors++; $display("FAIL rst_mid_adj: got %0d expected %0d", O_adj_active, ADJ_INIT); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd0, 1'b0);
      checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost%0d: got tvalid=%0b expected 0", i, O_tvalid); end
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b1, {4{24'hC86432}}, 1'b1, 1'b1, 1'b1, 9'sd255, 1'b0);
      else        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 9'sd0, 1'b0);
      if (i == 4) begin
        checks++;
        if (O_tvalid !== 1'b1 || O_tdata !== {4{24'hFF4C00}} || O_tuser !== 1'b1) begin
          errors++; $display("FAIL rst_mid_resume: got v=%0b u=%0b d=%h expected v=1 u=1 d=%h", O_tvalid, O_tuser, O_tdata, {4{24'hFF4C00}});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_greyscale();
    test_clamp();
    test_bypass();
    test_frame_latch();
    test_back_to_back_stall();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
